// File: rtl/ahb_mem_responder.sv
// ahb_mem_responder
//   Slave end of a word-wide AHB-lite-style bus. Holds a DEPTH x 64-bit array
//   mapped at BASE_ADDR. The address phase and data phase are pipelined, so a
//   new address can be accepted in the same cycle that a data phase completes.
//
//   Optional feature macro: AHB_MEM_WAIT_EN
//     defined   -> WAIT state and 4-bit counter built. Each data phase holds
//                  HREADY low for WAIT_CYCLES cycles (0..15).
//     undefined -> no WAIT state. Every data phase is zero-wait, and HREADY
//                  stays 1 after reset.
//
// Ports
//   CLK, RST_N         clock (rising edge), asynchronous active-low reset
//   HADDR[63:0]        byte address; bits [2:0] ignored
//   HWRITE, HTRANS     direction and transfer request for the address phase
//   HWDATA[63:0]       write data, valid in the write data phase
//   HRDATA[63:0]       registered read data
//   HREADY             registered; 0 only while a data phase is waiting
//   HRESP              1 during the data phase of an out-of-range transfer
//   busy               1 while a data phase is pending
module ahb_mem_responder #(
    parameter int unsigned DEPTH       = 1024,
    parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [63:0] HADDR,
    input  logic        HWRITE,
    input  logic        HTRANS,
    input  logic [63:0] HWDATA,
    output logic [63:0] HRDATA,
    output logic        HREADY,
    output logic        HRESP,
    output logic        busy
);

    localparam int          IDX_W    = $clog2(DEPTH);
    localparam logic [63:0] END_ADDR = BASE_ADDR + 64'(DEPTH) * 64'd8;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DATA} state_t;

    state_t             state_q, state_d, first_state;
    logic [IDX_W-1:0]   a_idx_q, a_idx_d;
    logic               a_write_q, a_write_d;
    logic               a_oor_q, a_oor_d;
    logic               hready_q, hready_d;
    logic               hresp_q, hresp_d;
    logic [63:0]        hrdata_q, hrdata_d;

    logic [63:0]        mem [DEPTH];

    logic               accept, commit;
    logic [63:0]        addr_off;
    logic [IDX_W-1:0]   in_idx, ent_idx;
    logic               in_oor, ent_oor, ent_write, from_bus;
    logic               unused_bits;

    assign accept   = HTRANS && hready_q;
    assign addr_off = HADDR - BASE_ADDR;
    assign in_idx   = addr_off[IDX_W+2:3];
    // Range check is done on the full address, so a truncated index is never
    // used for an address outside the array.
    assign in_oor   = (HADDR < BASE_ADDR) || (HADDR >= END_ADDR);
    // The pending write lands at the edge that ends its DATA cycle. A reset
    // forces IDLE, so a write interrupted by reset is dropped.
    assign commit   = (state_q == S_DATA) && a_write_q && !a_oor_q;

`ifdef AHB_MEM_WAIT_EN
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);
    logic [3:0] cnt_q, cnt_d;

    assign first_state = (WAIT_CYCLES != 0) ? S_WAIT : S_DATA;

    always_comb begin
        cnt_d = cnt_q;
        if (accept)
            cnt_d = WAIT_LOAD;
        else if (state_q == S_WAIT && cnt_q != 4'd0)
            cnt_d = cnt_q - 4'd1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) cnt_q <= 4'd0;
        else        cnt_q <= cnt_d;
    end

    assign unused_bits = ^{addr_off[63:IDX_W+3], addr_off[2:0]};
`else
    assign first_state = S_DATA;
    assign unused_bits = ^{addr_off[63:IDX_W+3], addr_off[2:0], WAIT_CYCLES};
`endif

    // FSM: state register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DATA: state_d = accept ? first_state : S_IDLE;
`ifdef AHB_MEM_WAIT_EN
            S_WAIT:         state_d = (cnt_q == 4'd0) ? S_DATA : S_WAIT;
`endif
            default:        state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        // DATA is entered either straight from the bus (zero-wait accept) or
        // from WAIT, where the transfer already sits in the a_* registers.
        from_bus  = (state_q != S_WAIT);
        ent_idx   = from_bus ? in_idx : a_idx_q;
        ent_oor   = from_bus ? in_oor : a_oor_q;
        ent_write = from_bus ? HWRITE : a_write_q;

        hready_d  = (state_d != S_WAIT);
        hresp_d   = (state_d == S_DATA) && ent_oor;

        hrdata_d  = hrdata_q;
        if (state_d == S_DATA && !ent_write) begin
            if (ent_oor)
                hrdata_d = 64'd0;
            else if (commit && a_idx_q == ent_idx)
                hrdata_d = HWDATA;  // write landing this edge to the same word
            else
                hrdata_d = mem[ent_idx];
        end

        a_idx_d   = accept ? in_idx : a_idx_q;
        a_write_d = accept ? HWRITE : a_write_q;
        a_oor_d   = accept ? in_oor : a_oor_q;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hready_q  <= 1'b1;
            hresp_q   <= 1'b0;
            hrdata_q  <= 64'd0;
            a_idx_q   <= '0;
            a_write_q <= 1'b0;
            a_oor_q   <= 1'b0;
        end else begin
            hready_q  <= hready_d;
            hresp_q   <= hresp_d;
            hrdata_q  <= hrdata_d;
            a_idx_q   <= a_idx_d;
            a_write_q <= a_write_d;
            a_oor_q   <= a_oor_d;
        end
    end

    // Array contents survive reset.
    always_ff @(posedge CLK) begin
        if (commit) mem[a_idx_q] <= HWDATA;
    end

    assign HREADY = hready_q;
    assign HRESP  = hresp_q;
    assign HRDATA = hrdata_q;
    assign busy   = (state_q != S_IDLE);

endmodule
